// File: rtl/trackball_pkg.sv
// rtl/trackball_pkg.sv - shared types, defaults and saturating arithmetic for the trackball encoder
package trackball_pkg;

  localparam int PHASE_DIV_DEF = 250;
  localparam int ACC_W_DEF     = 10;
  localparam int DELTA_W_DEF   = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } axis_state_t;

  // a + b clamped to the signed range of a w-bit two's complement number
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -hi - 32'sd1;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/trackball_axis.sv
// rtl/trackball_axis.sv - one axis: pending-count accumulator, phase divider and step FSM
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int PHASE_DIV = PHASE_DIV_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int DELTA_W   = DELTA_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               delta_valid,
  input  logic [DELTA_W-1:0] delta,
  output logic               dir,
  output logic               cnt,
  output logic               busy,
  output logic               ovf
);

  localparam int DIV_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PHASE_DIV - 1);

  axis_state_t             state;
  axis_state_t             state_nx;
  logic [DIV_W-1:0]        div;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nx;
  logic                    commit;
  logic                    phase_done;
  logic signed [31:0]      delta_ext;
  logic signed [31:0]      step_ext;
  logic signed [31:0]      sum_raw;
  logic signed [31:0]      sum_sat;

  // Fold the incoming delta and a step taken this cycle into one clamped accumulator update
  always_comb begin
    commit     = (state == ST_IDLE) && (acc != '0);
    phase_done = (div == DIV_LAST);
    delta_ext  = delta_valid ? 32'($signed(delta)) : 32'sd0;
    step_ext   = 32'sd0;
    if (commit) begin
      step_ext = acc[ACC_W-1] ? -32'sd1 : 32'sd1;
    end
    sum_raw = 32'(acc) + delta_ext - step_ext;
    sum_sat = sat_add(32'(acc), delta_ext - step_ext, ACC_W);
    acc_nx  = sum_sat[ACC_W-1:0];
    ovf     = !clear && (sum_sat != sum_raw);
  end

  // Step sequencing: direction setup, clock high, clock low, each one phase long
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (commit)     state_nx = ST_SETUP;
      ST_SETUP: if (phase_done) state_nx = ST_HIGH;
      ST_HIGH:  if (phase_done) state_nx = ST_LOW;
      ST_LOW:   if (phase_done) state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  // State, divider, accumulator and registered outputs; direction only moves on a commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      div   <= '0;
      acc   <= '0;
      dir   <= 1'b0;
      cnt   <= 1'b0;
      busy  <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;
      div   <= '0;
      acc   <= '0;
      cnt   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      div   <= ((state_nx != state) || (state_nx == ST_IDLE)) ? '0 : div + DIV_W'(1);
      cnt   <= (state_nx == ST_HIGH);
      busy  <= (acc_nx != '0) || (state_nx != ST_IDLE);
      if (commit) begin
        dir <= ~acc[ACC_W-1];
      end
    end
  end

endmodule

// File: rtl/trackball_quad_encoder.sv
// rtl/trackball_quad_encoder.sv - signed X/Y deltas to LETA trackball direction/clock pairs
module trackball_quad_encoder
  import trackball_pkg::*;
#(
  parameter int PHASE_DIV = PHASE_DIV_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int DELTA_W   = DELTA_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               delta_valid,
  input  logic [DELTA_W-1:0] dx,
  input  logic [DELTA_W-1:0] dy,
  input  logic               clear,
  output logic               HD,
  output logic               HC,
  output logic               VD,
  output logic               VC,
  output logic               busy,
  output logic               ovf
);

  logic busy_x;
  logic busy_y;
  logic ovf_x;
  logic ovf_y;

  trackball_axis #(
    .PHASE_DIV(PHASE_DIV),
    .ACC_W    (ACC_W),
    .DELTA_W  (DELTA_W)
  ) u_axis_x (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .delta_valid(delta_valid),
    .delta      (dx),
    .dir        (HD),
    .cnt        (HC),
    .busy       (busy_x),
    .ovf        (ovf_x)
  );

  trackball_axis #(
    .PHASE_DIV(PHASE_DIV),
    .ACC_W    (ACC_W),
    .DELTA_W  (DELTA_W)
  ) u_axis_y (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .delta_valid(delta_valid),
    .delta      (dy),
    .dir        (VD),
    .cnt        (VC),
    .busy       (busy_y),
    .ovf        (ovf_y)
  );

  assign busy = busy_x | busy_y;

  // Sticky saturation flag: any clamp on either axis holds until clear or reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (clear) begin
      ovf <= 1'b0;
    end else if (ovf_x || ovf_y) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trackball_quad_encoder.sv
// tb/tb_trackball_quad_encoder.sv - directed self-checking bench for trackball_quad_encoder
module tb_trackball_quad_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       delta_valid = 1'b0;
  logic       clear = 1'b0;
  logic [8:0] dx = '0;
  logic [8:0] dy = '0;
  logic hd, hc, vd, vc, busy, ovf;
  logic f_hd, f_hc, f_vd, f_vc, f_busy, f_ovf;

  trackball_quad_encoder dut (
    .clk(clk), .reset_n(reset_n), .delta_valid(delta_valid), .dx(dx), .dy(dy), .clear(clear),
    .HD(hd), .HC(hc), .VD(vd), .VC(vc), .busy(busy), .ovf(ovf)
  );

  trackball_quad_encoder #(.PHASE_DIV(4)) dut_fast (
    .clk(clk), .reset_n(reset_n), .delta_valid(delta_valid), .dx(dx), .dy(dy), .clear(clear),
    .HD(f_hd), .HC(f_hc), .VD(f_vd), .VC(f_vc), .busy(f_busy), .ovf(f_ovf)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  logic mon_rst = 1'b0;
  int hc_rises = 0, hc_up = 0, hc_down = 0, hc_first = -1, hd_glitch = 0;
  int vc_rises = 0, vc_up = 0, vc_down = 0, vd_age = 0, vd_min_setup = 1000000;
  int busy_fall = -1, f_rises = 0, f_up = 0, f_vrises = 0;
  logic hc_q = 1'b0, hd_q = 1'b0, vc_q = 1'b0, vd_q = 1'b0, busy_q = 1'b0;
  logic f_hc_q = 1'b0, f_vc_q = 1'b0;

  // Edge/level monitor sampled on the falling edge
  always @(negedge clk) begin
    if (mon_rst) begin
      hc_rises <= 0; hc_up <= 0; hc_down <= 0; hc_first <= -1; hd_glitch <= 0;
      vc_rises <= 0; vc_up <= 0; vc_down <= 0; vd_age <= 0; vd_min_setup <= 1000000;
      busy_fall <= -1; f_rises <= 0; f_up <= 0; f_vrises <= 0;
    end else begin
      if (hc && !hc_q) begin
        hc_rises <= hc_rises + 1;
        if (hd) hc_up <= hc_up + 1;
        else    hc_down <= hc_down + 1;
        if (hc_first < 0) hc_first <= cyc;
      end
      if (hc && hc_q && (hd !== hd_q)) hd_glitch <= hd_glitch + 1;
      vd_age <= (vd !== vd_q) ? 0 : vd_age + 1;
      if (vc && !vc_q) begin
        vc_rises <= vc_rises + 1;
        if (vd) vc_up <= vc_up + 1;
        else    vc_down <= vc_down + 1;
        if (vd_age < vd_min_setup) vd_min_setup <= vd_age;
      end
      if (!busy && busy_q && (busy_fall < 0)) busy_fall <= cyc;
      if (f_hc && !f_hc_q) begin
        f_rises <= f_rises + 1;
        if (f_hd) f_up <= f_up + 1;
      end
      if (f_vc && !f_vc_q) f_vrises <= f_vrises + 1;
    end
    hc_q <= hc; hd_q <= hd; vc_q <= vc; vd_q <= vd; busy_q <= busy;
    f_hc_q <= f_hc; f_vc_q <= f_vc;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic mon_reset();
    mon_rst = 1'b1;
    @(negedge clk);
    #1 mon_rst = 1'b0;
  endtask

  task automatic strobe(input logic [8:0] x, input logic [8:0] y, output int t0);
    @(negedge clk);
    dx = x; dy = y; delta_valid = 1'b1;
    @(negedge clk);
    delta_valid = 1'b0; dx = '0; dy = '0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input bit fast, input int budget, input string tag);
    int n = 0;
    while ((fast ? f_busy : busy) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(fast ? f_busy : busy), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #(64'd6_000_000);
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int t0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({hd, hc, vd, vc, busy, ovf}), 0);
    reset_n = 1'b1;
    mon_reset();

    // dx=+3: three up pulses, first rise 251 cycles after strobe, idle at 3*751
    strobe(9'd3, 9'd0, t0);
    wait_idle(1'b0, 3000, "t1_idle");
    chk("t1_first_rise", hc_first - t0, 251);
    chk("t1_hc_rises", hc_rises, 3);
    chk("t1_hc_up", hc_up, 3);
    chk("t1_hd_glitch", hd_glitch, 0);
    chk("t1_busy_fall", busy_fall - t0, 2253);
    chk("t1_vc_rises", vc_rises, 0);
    chk("t1_ovf", int'(ovf), 0);

    // dy=-2: two down pulses on the vertical axis, horizontal quiet
    mon_reset();
    strobe(9'd0, -9'sd2, t0);
    wait_idle(1'b0, 2000, "t2_idle");
    chk("t2_vc_rises", vc_rises, 2);
    chk("t2_vc_down", vc_down, 2);
    chk("t2_vd_setup_ok", int'(vd_min_setup >= 249), 1);
    chk("t2_hc_rises", hc_rises, 0);
    chk("t2_busy_fall", busy_fall - t0, 1502);

    // dx=+2 then dx=-5 while step one is in setup: 1 up, then 4 down
    mon_reset();
    strobe(9'd2, 9'd0, t0);
    repeat (98) @(negedge clk);
    strobe(-9'sd5, 9'd0, t0);
    wait_idle(1'b0, 5000, "t3_idle");
    chk("t3_hc_rises", hc_rises, 5);
    chk("t3_hc_up", hc_up, 1);
    chk("t3_hc_down", hc_down, 4);
    chk("t3_hd_glitch", hd_glitch, 0);

    // four back-to-back +200 strobes: 200, 399 (one step taken), clamp 511, clamp 511
    mon_reset();
    @(negedge clk);
    dx = 9'd200; delta_valid = 1'b1;
    repeat (4) @(negedge clk);
    delta_valid = 1'b0; dx = '0;
    chk("t4_ovf_set", int'(ovf), 1);
    chk("t4_fast_ovf_set", int'(f_ovf), 1);
    wait_idle(1'b1, 8000, "t4_fast_idle");
    chk("t4_fast_rises", f_rises, 512);
    chk("t4_fast_up", f_up, 512);
    chk("t4_fast_vrises", f_vrises, 0);
    chk("t4_fast_vd", int'(f_vd), 0);
    chk("t4_fast_ovf_sticky", int'(f_ovf), 1);
    chk("t4_ovf_sticky", int'(ovf), 1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t4_clear_ovf", int'(ovf), 0);
    chk("t4_clear_busy", int'(busy), 0);
    chk("t4_clear_hc", int'(hc), 0);
    chk("t4_clear_hd_held", int'(hd), 1);
    chk("t4_clear_fast_ovf", int'(f_ovf), 0);
    repeat (20) @(negedge clk);
    chk("t4_after_clear_busy", int'(busy), 0);

    // +5 then +1 on the commit cycle: 5 + 1 - 1 -> 5 pending, 6 pulses total
    mon_reset();
    @(negedge clk);
    dx = 9'd5; delta_valid = 1'b1;
    @(negedge clk);
    dx = 9'd1;
    @(negedge clk);
    delta_valid = 1'b0; dx = '0;
    wait_idle(1'b0, 6000, "t5_idle");
    chk("t5_hc_rises", hc_rises, 6);
    chk("t5_hc_up", hc_up, 6);
    chk("t5_fast_rises", f_rises, 6);

    // async reset during HIGH with 7 steps pending
    mon_reset();
    strobe(9'd8, 9'd0, t0);
    for (int n = 0; (n < 400) && !hc; n++) @(negedge clk);
    chk("t6_high_reached", int'(hc), 1);
    repeat (10) @(negedge clk);
    #7 reset_n = 1'b0;
    #1 chk("t6_async_reset", int'({hd, hc, vd, vc, busy, ovf}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_reset();
    repeat (1000) @(negedge clk);
    chk("t6_no_pulses", hc_rises, 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_hd", int'(hd), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
